// File: rtl/pipelined_instruction_memory_pkg.sv
// Shared definitions for the pipelined instruction memory: sequencer state
// encoding, the default bubble word and the word-index width helper.
package imem_pkg;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } imem_state_e;

  // sll $0,$0,0 -- the canonical MIPS bubble
  localparam logic [31:0] IMEM_NOP_DEFAULT = 32'h0000_0000;

  // Bits needed to index DEPTH words; never narrower than one bit
  function automatic int imem_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipelined_instruction_memory_loader.sv
// Program-load sequencer for the instruction memory.
// Walks a write pointer through the array while in LOAD and hands control to
// RUN on load_done. RUN is only left through reset.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_LOAD | accepting program words at load_count, outputs held at NOP
//   ST_RUN  | fetching; load port ignored, load_count frozen
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid_i,
  input  logic             load_done_i,
  output imem_state_e      state_o,
  output logic [CNT_W-1:0] load_count_o,
  output logic             load_ready_o,
  output logic             wr_en_o
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  imem_state_e      state_q;
  logic [CNT_W-1:0] load_count_q;

  // Ready is combinational so a source sees the full/running condition
  // in the same cycle it would present a beat.
  assign load_ready_o = (state_q == ST_LOAD) && (load_count_q < DEPTH_C);
  assign wr_en_o      = load_valid_i && load_ready_o;
  assign state_o      = state_q;
  assign load_count_o = load_count_q;

  // Sequencer: pointer advances on each accepted beat; load_done switches to
  // RUN on the same edge that may still commit a final beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_LOAD;
      load_count_q <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (wr_en_o) load_count_q <= load_count_q + 1'b1;
          if (load_done_i) state_q <= ST_RUN;
        end
        ST_RUN: begin
          state_q <= ST_RUN;
        end
        default: begin
          state_q <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipelined_instruction_memory.sv
// Synchronous-read instruction memory for the IF stage with hazard-unit
// stall/flush and a sequential program-load port.
// Optional feature macro: PIPELINED_IMEM_FAULT_CHECK_EN enables misalignment
// and range checking of pc; without it fault stays 0 and the index wraps.
module pipelined_instruction_memory
  import imem_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 32,
  parameter int                ADDR_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(IMEM_NOP_DEFAULT)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          pc,
  input  logic                       stall,
  input  logic                       flush,
  output logic [DATA_W-1:0]          instruction,
  output logic                       instr_valid,
  output logic                       fault,
  input  logic                       load_valid,
  input  logic [DATA_W-1:0]          load_data,
  output logic                       load_ready,
  input  logic                       load_done,
  output logic [$clog2(DEPTH+1)-1:0] load_count
);

  localparam int IDX_W = imem_idx_w(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  imem_state_e      ld_state;
  logic             wr_en;
  logic [CNT_W-1:0] ld_count;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] instr_q;
  logic              valid_q;
  logic              fault_q;

  logic [IDX_W-1:0]  fetch_idx;
  logic              fetch_bad;

  imem_loader #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_loader (
    .clk          (clk),
    .reset        (reset),
    .load_valid_i (load_valid),
    .load_done_i  (load_done),
    .state_o      (ld_state),
    .load_count_o (ld_count),
    .load_ready_o (load_ready),
    .wr_en_o      (wr_en)
  );

  assign load_count = ld_count;
  assign fetch_idx  = pc[IDX_W+1:2];

`ifdef PIPELINED_IMEM_FAULT_CHECK_EN
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  assign fetch_bad = (pc[1:0] != 2'b00) || ((pc >> 2) >= DEPTH_A);
`else
  // Byte-offset and above-range pc bits are deliberately discarded here.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc[ADDR_W-1:IDX_W+2], pc[1:0]};
  assign fetch_bad      = 1'b0;
`endif

  // Program storage; deliberately not reset so a reset in RUN keeps the image.
  always_ff @(posedge clk) begin
    if (wr_en) mem[ld_count[IDX_W-1:0]] <= load_data;
  end

  // Fetch register: reset > LOAD bubble > flush > stall (hold) > fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else if (ld_state != ST_RUN) begin
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else if (flush) begin
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else if (!stall) begin
      if (fetch_bad) begin
        instr_q <= NOP_WORD;
        valid_q <= 1'b0;
        fault_q <= 1'b1;
      end else begin
        instr_q <= mem[fetch_idx];
        valid_q <= 1'b1;
        fault_q <= 1'b0;
      end
    end
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_pipelined_instruction_memory.sv
// Bench for pipelined_instruction_memory: a DEPTH=32 instance checked every
// cycle against a behavioural model, plus a DEPTH=4 instance for load-port
// saturation. Honours PIPELINED_IMEM_FAULT_CHECK_EN when deciding expectations.
module tb_pipelined_instruction_memory;

  localparam int D = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT
  logic        reset = 1'b1, stall = 1'b0, flush = 1'b0;
  logic        load_valid = 1'b0, load_done = 1'b0;
  logic [31:0] pc = '0, load_data = '0;
  logic [31:0] instruction;
  logic        instr_valid, fault, load_ready;
  logic [5:0]  load_count;

  pipelined_instruction_memory #(.DATA_W(32), .DEPTH(D), .ADDR_W(32),
                                 .NOP_WORD(32'h0)) u_dut (
    .clk(clk), .reset(reset), .pc(pc), .stall(stall), .flush(flush),
    .instruction(instruction), .instr_valid(instr_valid), .fault(fault),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .load_done(load_done), .load_count(load_count));

  // small DUT
  logic        s_reset = 1'b1, s_load_valid = 1'b0, s_load_done = 1'b0;
  logic [31:0] s_pc = '0, s_load_data = '0;
  logic [31:0] s_instruction;
  logic        s_instr_valid, s_fault, s_load_ready;
  logic [2:0]  s_load_count;

  pipelined_instruction_memory #(.DATA_W(32), .DEPTH(4), .ADDR_W(32),
                                 .NOP_WORD(32'h0)) u_small (
    .clk(clk), .reset(s_reset), .pc(s_pc), .stall(1'b0), .flush(1'b0),
    .instruction(s_instruction), .instr_valid(s_instr_valid), .fault(s_fault),
    .load_valid(s_load_valid), .load_data(s_load_data),
    .load_ready(s_load_ready), .load_done(s_load_done),
    .load_count(s_load_count));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- behavioural model of the main DUT ----------------
  bit          m_run;
  int          m_cnt;
  logic [31:0] m_mem [D];
  logic [31:0] e_instr;
  bit          e_valid, e_fault;
  bit          chk_en = 1'b0;

  function automatic bit pc_faults(input logic [31:0] a);
`ifdef PIPELINED_IMEM_FAULT_CHECK_EN
    return (a % 4 != 0) || (a / 4 >= D);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_run = 0; m_cnt = 0;
      e_instr = 32'h0; e_valid = 0; e_fault = 0;
    end else if (!m_run) begin
      if (load_valid && m_cnt < D) begin
        m_mem[m_cnt] = load_data;
        m_cnt++;
      end
      if (load_done) m_run = 1;
      e_instr = 32'h0; e_valid = 0; e_fault = 0;
    end else if (flush) begin
      e_instr = 32'h0; e_valid = 0; e_fault = 0;
    end else if (!stall) begin
      if (pc_faults(pc)) begin
        e_instr = 32'h0; e_valid = 0; e_fault = 1;
      end else begin
        e_instr = m_mem[(pc / 4) % D]; e_valid = 1; e_fault = 0;
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("instruction", instruction, e_instr);
      check("instr_valid", 32'(instr_valid), 32'(e_valid));
      check("fault", 32'(fault), 32'(e_fault));
      check("load_count", 32'(load_count), 32'(m_cnt));
      check("load_ready", 32'(load_ready), 32'(!m_run && m_cnt < D));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int r, guard;

    // small instance: saturation at DEPTH=4, no wrap-around
    step();
    s_reset = 1'b0;
    check("s_rst_count", 32'(s_load_count), 32'd0);
    check("s_rst_ready", 32'(s_load_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      s_load_valid = 1'b1;
      s_load_data  = 32'h11 + 32'(i);
      step();
      if (i == 3) check("s_ready_after4", 32'(s_load_ready), 32'd0);
    end
    check("s_count_sat", 32'(s_load_count), 32'd4);
    s_load_valid = 1'b0;
    s_load_done  = 1'b1;
    step();
    s_load_done = 1'b0;
    s_pc = 32'd0;
    step();
    check("s_mem0_kept", s_instruction, 32'h11);
    s_pc = 32'd12;
    step();
    check("s_mem3", s_instruction, 32'h14);

    // main instance: reset values
    reset = 1'b1;
    step();
    chk_en = 1'b1;
    reset  = 1'b0;
    check("rst_instr", instruction, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_count", 32'(load_count), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd1);

    // fill every word with gaps, then offer extra beats past full
    guard = 0;
    while (m_cnt < D && guard < 1000) begin
      load_valid = ($urandom % 3) != 0;
      load_data  = $urandom;
      step();
      guard++;
    end
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = $urandom;
      step();
    end
    load_valid = 1'b0;
    check("full_count", 32'(load_count), 32'd32);
    check("full_ready", 32'(load_ready), 32'd0);

    // directed program load
    reset = 1'b1; step(); reset = 1'b0;
    load_valid = 1'b1; load_data = 32'h8D09_0000; step();
    load_data = 32'h2129_0001; step();
    load_valid = 1'b0; load_done = 1'b1; step();
    load_done = 1'b0;
    check("run_no_fetch_yet", 32'(instr_valid), 32'd0);
    pc = 32'd0; step();
    check("fetch_pc0", instruction, 32'h8D09_0000);
    check("fetch_pc0_valid", 32'(instr_valid), 32'd1);
    pc = 32'd4; step();
    check("fetch_pc4", instruction, 32'h2129_0001);

    // stall holds for two cycles, then the new pc lands one cycle later
    pc = 32'd0; step();
    pc = 32'd4; stall = 1'b1; step();
    check("stall_hold1", instruction, 32'h8D09_0000);
    step();
    check("stall_hold2", instruction, 32'h8D09_0000);
    stall = 1'b0; step();
    check("after_stall", instruction, 32'h2129_0001);

    // flush beats stall
    stall = 1'b1; flush = 1'b1; step();
    check("flush_instr", instruction, 32'h0);
    check("flush_valid", 32'(instr_valid), 32'd0);
    stall = 1'b0; flush = 1'b0;

    // misaligned / out-of-range pcs
    pc = 32'd2; step();
`ifdef PIPELINED_IMEM_FAULT_CHECK_EN
    check("pc2_fault", 32'(fault), 32'd1);
    check("pc2_instr", instruction, 32'h0);
`else
    check("pc2_fault", 32'(fault), 32'd0);
    check("pc2_instr", instruction, 32'h8D09_0000);
`endif
    pc = 32'd128; step();
`ifdef PIPELINED_IMEM_FAULT_CHECK_EN
    check("pc128_fault", 32'(fault), 32'd1);
    check("pc128_valid", 32'(instr_valid), 32'd0);
    check("pc128_instr", instruction, 32'h0);
`else
    check("pc128_fault", 32'(fault), 32'd0);
    check("pc128_valid", 32'(instr_valid), 32'd1);
    check("pc128_instr", instruction, 32'h8D09_0000);
`endif

    // reset mid-load keeps already-written words
    reset = 1'b1; step(); reset = 1'b0;
    load_valid = 1'b1; load_data = 32'hAAAA_0000; step();
    load_data = 32'hBBBB_0001; step();
    load_valid = 1'b0; reset = 1'b1; step(); reset = 1'b0;
    check("midrst_count", 32'(load_count), 32'd0);
    check("midrst_ready", 32'(load_ready), 32'd1);
    load_valid = 1'b1; load_data = 32'hCCCC_0002; load_done = 1'b1; step();
    load_valid = 1'b0; load_done = 1'b0;
    check("final_beat_count", 32'(load_count), 32'd1);
    pc = 32'd4; step();
    check("kept_word", instruction, 32'hBBBB_0001);
    pc = 32'd0; step();
    check("reloaded_word", instruction, 32'hCCCC_0002);

    // randomized run with occasional reset + partial reload
    for (int c = 0; c < 3000; c++) begin
      if ($urandom % 150 == 0) begin
        stall = 1'b0; flush = 1'b0;
        reset = 1'b1; step(); reset = 1'b0;
        r = $urandom_range(0, 4);
        for (int k = 0; k < r; k++) begin
          load_valid = ($urandom % 4) != 0;
          load_data  = $urandom;
          step();
        end
        load_valid = $urandom % 2;
        load_data  = $urandom;
        load_done  = 1'b1;
        step();
        load_done = 1'b0;
      end
      r = $urandom % 10;
      if (r < 8)       pc = 32'($urandom_range(0, D - 1)) << 2;
      else if (r == 8) pc = (32'($urandom_range(0, D - 1)) << 2) |
                            32'($urandom_range(1, 3));
      else             pc = 32'($urandom_range(D, 200)) << 2;
      stall      = ($urandom % 5) == 0;
      flush      = ($urandom % 10) == 0;
      load_valid = $urandom % 2;
      load_data  = $urandom;
      step();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipelined_instruction_memory.md
# pipelined_instruction_memory

Parametrised, synchronous-read instruction memory for the IF stage of the pipelined MIPS datapath. It replaces the fixed 32×32 combinational memory with a memory of configurable depth and width. It has a one-cycle registered fetch and hazard-unit stall/flush inputs. A sequential load port lets the bench or a boot source write the program before execution starts.

## Interface
- DATA_W, 32, instruction word width in bits
- DEPTH, 32, number of words; power of two, at least 4
- ADDR_W, 32, byte-address width of `pc`
- NOP_WORD, 32'h00000000, word driven when no valid instruction is available (sll $0,$0,0)

One clock: `clk`. Reset: `reset`, synchronous and active-high.
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- pc  input  ADDR_W  byte address to fetch; sampled each edge in RUN
- stall  input  1  hazard unit: hold the current output
- flush  input  1  hazard unit: replace the next output with NOP_WORD
- instruction  output  DATA_W  registered fetched word
- instr_valid  output  1  `instruction` is a real fetch from memory
- fault  output  1  the last sampled `pc` was misaligned or out of range (only with the macro)
- load_valid  input  1  `load_data` is presented
- load_data  input  DATA_W  word written at the load pointer
- load_ready  output  1  a load write is accepted this cycle
- load_done  input  1  ends loading and enters RUN
- load_count  output  $clog2(DEPTH+1)  number of words written so far

## Operation
- States: LOAD (entered on reset) and RUN.
- LOAD
  - `load_ready` = 1 while `load_count` < DEPTH.
  - When `load_valid` && `load_ready`: write `mem[load_count]` = `load_data`, then `load_count` += 1.
  - When `load_count` == DEPTH, `load_ready` drops. Further `load_valid` beats are dropped. There is no wrap-around.
  - `load_done` moves the FSM to RUN on the next edge. If `load_valid` is asserted in the same cycle, that final write is still performed.
- RUN
  - Word index = `pc[$clog2(DEPTH)+1:2]`.
  - Load port is ignored; `load_ready` = 0; `load_count` is frozen.
  - RUN is left only through `reset`.
- Output register priority per edge: reset > flush > stall > fetch.
  - flush: `instruction` = NOP_WORD, `instr_valid` = 0, `fault` = 0.
  - stall: `instruction`, `instr_valid` and `fault` all hold.
  - fetch: `instruction` = `mem[index]`, `instr_valid` = 1.
- Faults (with the macro): a fetch faults if `pc[1:0]` != 0 or if `pc >> 2` >= DEPTH.
  - A faulting fetch registers NOP_WORD, `instr_valid` = 0, `fault` = 1.
- In LOAD: `instruction` = NOP_WORD, `instr_valid` = 0, `fault` = 0.
- Memory contents are not cleared by reset. Only the pointer, state and outputs reset.

## Timing
- Reset values:
  - `instruction` = NOP_WORD
  - `instr_valid` = 0
  - `fault` = 0
  - `load_count` = 0
  - `load_ready` = 1 (state is LOAD)
- Fetch latency is one cycle: the `pc` sampled at edge n appears on `instruction` after edge n.
- The first valid fetch is possible on the first edge after the one that entered RUN.
- `load_ready` is combinational from state and `load_count`. A write completes at the edge where `load_valid` && `load_ready`.
- Reset asserted mid-load returns the block to LOAD with `load_count` = 0. Words already written stay in memory.
- Reset asserted in RUN returns to LOAD. The program must be reloaded or `load_done` re-asserted; the old contents remain valid.
- When stall and flush are asserted together, flush wins.

## Configuration
- `PIPELINED_IMEM_FAULT_CHECK_EN`
  - Defined: misalignment and range checks are active and `fault` behaves as described above.
  - Undefined: `fault` is tied to 0 and no checks are made. The index is taken modulo DEPTH and the low two `pc` bits are ignored.

## Structure
- Shared package `imem_pkg` holds:
  - the state enum (LOAD, RUN)
  - the default NOP_WORD constant
  - a `$clog2`-derived index width helper
- One sub-module, `imem_loader`, holds:
  - the LOAD/RUN FSM
  - the `load_count` pointer
  - the `load_ready`/write-enable generation
- Storage and the output register stay in the top level.

## Test plan
- Reset, load 8D090000 then 21290001, assert `load_done`, fetch pc=0 then pc=4 → 8D090000 then 21290001 with `instr_valid` = 1, each one cycle after its `pc`.
- In RUN, fetch pc=0, then pc=4 with `stall` = 1 for two cycles → `instruction` holds 8D090000; after `stall` drops, 21290001 appears one cycle later.
- Fetch pc=4 with `stall` = 1 and `flush` = 1 together → `instruction` = 00000000 and `instr_valid` = 0 on the next cycle.
- Macro defined, DEPTH=32: fetch pc=2 and pc=128 → each gives `fault` = 1, `instr_valid` = 0, `instruction` = 00000000. With the macro undefined, pc=128 returns `mem[0]`.
- DEPTH=4: offer 6 load beats → `load_count` stops at 4, `load_ready` = 0 after the fourth write, and `mem[0]` is not overwritten.
- Write 2 words, assert `reset` mid-load → `load_count` = 0 and state is LOAD. Reload 1 word, assert `load_done`, fetch pc=4 → the word written before reset is still returned.
